// File: rtl/adf4159_hop_pkg.sv
// rtl/adf4159_hop_pkg.sv - shared widths and FSM states for the adf4159 hop scheduler
package adf4159_hop_pkg;

    localparam int INT_W   = 12;
    localparam int FRAC_W  = 25;
    localparam int ENTRY_W = INT_W + FRAC_W;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        PRE_RD,
        PRE_REQ,
        PRE_WAIT,
        DWELL_WAIT,
        LOAD_REQ,
        LOAD_WAIT,
        NEXT,
        ABORT_DWELL
    } hop_state_t;

endpackage

// File: rtl/adf4159_hop_table.sv
// rtl/adf4159_hop_table.sv - hop point table, one write port, registered read port
module adf4159_hop_table
    import adf4159_hop_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [0:(1<<AW)-1];
    logic [ENTRY_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only updates on i_re, so it doubles as the held adf_ints/adf_fracs value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adf4159_hop_sched.sv
// rtl/adf4159_hop_sched.sv - adf4159 frequency-hop scheduler; HOP_EXT_TRIG_EN adds the hop_trig input
module adf4159_hop_sched
    import adf4159_hop_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [INT_W-1:0]  cfg_ints,
    input  logic [FRAC_W-1:0] cfg_fracs,
    input  logic [AW-1:0]     last_index,
    input  logic [DW-1:0]     dwell,
    input  logic              continuous,
    input  logic              start,
    input  logic              stop,
`ifdef HOP_EXT_TRIG_EN
    input  logic              hop_trig,
`endif
    input  logic              adf_busy,
    output logic              adf_pre_load,
    output logic              adf_load,
    output logic [INT_W-1:0]  adf_ints,
    output logic [FRAC_W-1:0] adf_fracs,
    output logic              busy,
    output logic              hop_strobe,
    output logic [AW-1:0]     hop_index,
    output logic              done,
    output logic              overrun
);

    hop_state_t         r_state, w_state_next;
    logic [AW-1:0]      r_idx, r_last, r_hop_index;
    logic               r_cont, r_first, r_stop_pend, r_overrun, r_busy, r_hop_strobe, r_done;
    logic               w_go, w_hop, w_fin, w_expired, w_abort_ok, w_in_pre, w_rd_en;
    logic [ENTRY_W-1:0] w_rd_data;

    assign w_rd_en  = (r_state == PRE_RD);
    assign w_in_pre = (r_state == PRE_RD) || (r_state == PRE_REQ) || (r_state == PRE_WAIT);

    adf4159_hop_table #(.AW(AW)) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata ({cfg_ints, cfg_fracs}),
        .i_re    (w_rd_en),
        .i_raddr (r_idx),
        .o_rdata (w_rd_data)
    );

`ifdef HOP_EXT_TRIG_EN
    logic r_trig;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_trig <= 1'b0;
        end else if (w_hop || w_go) begin
            r_trig <= 1'b0;
        end else if (hop_trig && w_in_pre && !r_first) begin
            r_trig <= 1'b1;
        end
    end

    assign w_expired  = hop_trig | r_trig;
    assign w_abort_ok = 1'b1;
`else
    logic [DW-1:0] r_dwell, r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dwell <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_go) begin
                r_dwell <= dwell;
            end
            if (w_hop) begin
                r_cnt <= (r_dwell == '0) ? DW'(1) : r_dwell;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Expiry means the count hits 0 on this edge, so a dwell of N ends N cycles after the hop.
    assign w_expired  = (r_cnt <= DW'(1));
    assign w_abort_ok = w_expired;
`endif

    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_hop        = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            INIT:        if (!adf_busy) w_state_next = IDLE;
            IDLE: begin
                if (start && !stop) begin
                    w_go         = 1'b1;
                    w_state_next = PRE_RD;
                end
            end
            PRE_RD:      w_state_next = PRE_REQ;
            PRE_REQ:     if (adf_busy) w_state_next = PRE_WAIT;
            PRE_WAIT: begin
                if (!adf_busy) begin
                    w_state_next = (r_first || w_expired) ? LOAD_REQ : DWELL_WAIT;
                end
            end
            DWELL_WAIT:  if (w_expired) w_state_next = LOAD_REQ;
            LOAD_REQ:    if (adf_busy) w_state_next = LOAD_WAIT;
            LOAD_WAIT: begin
                if (!adf_busy) begin
                    w_hop        = 1'b1;
                    w_state_next = NEXT;
                end
            end
            NEXT: begin
                if (r_stop_pend || ((r_idx == r_last) && !r_cont)) begin
                    w_state_next = ABORT_DWELL;
                end else begin
                    w_state_next = PRE_RD;
                end
            end
            ABORT_DWELL: begin
                if (w_abort_ok) begin
                    w_fin        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default:     w_state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= INIT;
            r_idx        <= '0;
            r_last       <= '0;
            r_cont       <= 1'b0;
            r_first      <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
            r_hop_strobe <= 1'b0;
            r_hop_index  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next != IDLE);
            r_hop_strobe <= w_hop;
            r_done       <= w_fin;
            if (w_go) begin
                r_last      <= last_index;
                r_cont      <= continuous;
                r_idx       <= '0;
                r_first     <= 1'b1;
                r_overrun   <= 1'b0;
                r_stop_pend <= 1'b0;
            end else begin
                if (w_fin) begin
                    r_stop_pend <= 1'b0;
                end else if (stop && (r_state != IDLE) && (r_state != INIT)) begin
                    r_stop_pend <= 1'b1;
                end
                if (w_expired && w_in_pre && !r_first) begin
                    r_overrun <= 1'b1;
                end
                if (w_hop) begin
                    r_hop_index <= r_idx;
                    r_first     <= 1'b0;
                end
                if ((r_state == NEXT) && (w_state_next == PRE_RD)) begin
                    r_idx <= (r_idx == r_last) ? '0 : r_idx + 1'b1;
                end
            end
        end
    end

    assign adf_pre_load = (r_state == PRE_REQ);
    assign adf_load     = (r_state == LOAD_REQ);
    assign adf_ints     = w_rd_data[ENTRY_W-1:FRAC_W];
    assign adf_fracs    = w_rd_data[FRAC_W-1:0];
    assign busy         = r_busy;
    assign hop_strobe   = r_hop_strobe;
    assign hop_index    = r_hop_index;
    assign done         = r_done;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_adf4159_hop_sched.sv
// tb/tb_adf4159_hop_sched.sv - directed self-checking bench for adf4159_hop_sched
module tb_adf4159_hop_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [11:0] cfg_ints = '0;
    logic [24:0] cfg_fracs = '0;
    logic [3:0]  last_index = '0;
    logic [23:0] dwell = '0;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        adf_busy = 1'b1;
    logic        adf_pre_load, adf_load, busy, hop_strobe, done, overrun;
    logic [11:0] adf_ints;
    logic [24:0] adf_fracs;
    logic [3:0]  hop_index;

    adf4159_hop_sched #(.AW(4), .DW(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_ints     (cfg_ints),
        .cfg_fracs    (cfg_fracs),
        .last_index   (last_index),
        .dwell        (dwell),
        .continuous   (continuous),
        .start        (start),
        .stop         (stop),
        .adf_busy     (adf_busy),
        .adf_pre_load (adf_pre_load),
        .adf_load     (adf_load),
        .adf_ints     (adf_ints),
        .adf_fracs    (adf_fracs),
        .busy         (busy),
        .hop_strobe   (hop_strobe),
        .hop_index    (hop_index),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // adf4159 model state and event log
    logic        m_force = 1'b1;
    int          m_xfer = 4;
    int          m_cnt = 0;
    logic        m_hold = 1'b0;
    logic        m_prev_pre = 1'b0;
    logic        m_prev_load = 1'b0;
    logic [11:0] m_cap_i = '0;
    logic [24:0] m_cap_f = '0;
    int          v_both = 0;
    int          v_rise_busy = 0;
    int          v_unstable = 0;
    int          n_load = 0;
    int          q_hop_idx[$];
    int          q_hop_cyc[$];
    int          q_pre_ints[$];
    int          q_pre_fracs[$];
    int          q_done_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic pre_rise, load_rise;
        pre_rise  = adf_pre_load && !m_prev_pre;
        load_rise = adf_load && !m_prev_load;
        if (adf_pre_load && adf_load) v_both++;
        if ((pre_rise || load_rise) && adf_busy) v_rise_busy++;
        if (pre_rise) begin
            q_pre_ints.push_back(int'(adf_ints));
            q_pre_fracs.push_back(int'(adf_fracs));
        end
        if (load_rise) n_load++;
        if (pre_rise || load_rise) begin
            m_hold  = 1'b1;
            m_cap_i = adf_ints;
            m_cap_f = adf_fracs;
        end else if (m_hold && ((adf_ints !== m_cap_i) || (adf_fracs !== m_cap_f))) begin
            v_unstable++;
        end
        if (hop_strobe) begin
            q_hop_idx.push_back(int'(hop_index));
            q_hop_cyc.push_back(cyc);
        end
        if (done) q_done_cyc.push_back(cyc);
        m_prev_pre  = adf_pre_load;
        m_prev_load = adf_load;
        if (m_force) begin
            adf_busy = 1'b1;
            m_cnt    = 0;
            m_hold   = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                adf_busy = 1'b0;
                m_hold   = 1'b0;
            end
        end else if (adf_pre_load || adf_load) begin
            adf_busy = 1'b1;
            m_cnt    = m_xfer;
        end else begin
            adf_busy = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] i, input logic [24:0] f);
        cfg_we = 1'b1; cfg_addr = a; cfg_ints = i; cfg_fracs = f;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic clear_log();
        q_hop_idx.delete(); q_hop_cyc.delete(); q_pre_ints.delete();
        q_pre_fracs.delete(); q_done_cyc.delete();
        n_load = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k = 0;
        while (q_done_cyc.size() == 0 && k < limit) begin tick(1); k++; end
        check_eq(tag, q_done_cyc.size() != 0, 1);
    endtask

    task automatic wait_hops(input int n, input int limit, input string tag);
        int k = 0;
        while (q_hop_idx.size() < n && k < limit) begin tick(1); k++; end
        check_eq(tag, q_hop_idx.size() >= n, 1);
    endtask

    task automatic wait_pre(input int n, input int limit, input string tag);
        int k = 0;
        while (q_pre_ints.size() < n && k < limit) begin tick(1); k++; end
        check_eq(tag, q_pre_ints.size() >= n, 1);
    endtask

    initial begin
        int e_busy = 0;
        int e_req = 0;
        int e_ints[3] = '{100, 101, 102};
        int e_fracs[3] = '{0, 32'h100000, 1};
        int e_lap[3] = '{0, 1, 0};

        // reset and adf4159 power-up
        tick(3);
        check_eq("rst_outputs", {adf_pre_load, adf_load, busy, hop_strobe, done, overrun,
                                 hop_index, adf_ints, adf_fracs}, '0);
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 50; i++) begin
            if (busy !== 1'b1) e_busy++;
            if (adf_pre_load || adf_load) e_req++;
            tick(1);
        end
        check_eq("init_busy_high", e_busy, 0);
        check_eq("init_no_req", e_req, 0);
        m_force = 1'b0;
        tick(1);
        check_eq("init_to_idle", busy, 0);

        // single sweep, 3 points, dwell 200
        wr(4'd0, 12'd100, 25'd0);
        wr(4'd1, 12'd101, 25'h100000);
        wr(4'd2, 12'd102, 25'd1);
        wr(4'd3, 12'd999, 25'h1abcde);
        clear_log();
        last_index = 4'd2; dwell = 24'd200; continuous = 1'b0;
        pulse_start();
        wait_done(2000, "s_done_seen");
        check_eq("s_hop_count", q_hop_idx.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("s_hop_idx%0d", i), q_hop_idx[i], i);
            check_eq($sformatf("s_pre_ints%0d", i), q_pre_ints[i], e_ints[i]);
            check_eq($sformatf("s_pre_fracs%0d", i), q_pre_fracs[i], e_fracs[i]);
        end
        check_eq("s_gap01", (q_hop_cyc[1] - q_hop_cyc[0]) >= 200, 1);
        check_eq("s_gap12", (q_hop_cyc[2] - q_hop_cyc[1]) >= 200, 1);
        check_eq("s_done_delay", q_done_cyc[0] - q_hop_cyc[2], 200);
        check_eq("s_load_count", n_load, 3);
        check_eq("s_no_overrun", overrun, 0);
        check_eq("s_idle", busy, 0);

        // continuous lap with stop during second-lap pre_load of index 0
        clear_log();
        last_index = 4'd1; dwell = 24'd50; continuous = 1'b1;
        pulse_start();
        wait_pre(3, 2000, "c_pre3_seen");
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(2000, "c_done_seen");
        tick(20);
        check_eq("c_hop_count", q_hop_idx.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("c_hop_idx%0d", i), q_hop_idx[i], e_lap[i]);
            check_eq($sformatf("c_pre_ints%0d", i), q_pre_ints[i], e_ints[e_lap[i]]);
        end
        check_eq("c_done_delay", q_done_cyc[0] - q_hop_cyc[2], 50);
        check_eq("c_pre_count", q_pre_ints.size(), 3);
        check_eq("c_load_count", n_load, 3);
        check_eq("c_idle", busy, 0);

        // overrun with a slow adf4159
        clear_log();
        m_xfer = 300;
        last_index = 4'd2; dwell = 24'd5; continuous = 1'b0;
        pulse_start();
        wait_done(6000, "o_done_seen");
        check_eq("o_overrun", overrun, 1);
        check_eq("o_hop_count", q_hop_idx.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("o_hop_idx%0d", i), q_hop_idx[i], i);
        end

        // next start clears overrun; start during the sweep is ignored
        clear_log();
        m_xfer = 4;
        last_index = 4'd2; dwell = 24'd30; continuous = 1'b0;
        pulse_start();
        check_eq("r_overrun_cleared", overrun, 0);
        check_eq("r_busy", busy, 1);
        wait_hops(1, 500, "r_hop0_seen");
        last_index = 4'd0; dwell = 24'd7; continuous = 1'b1;
        pulse_start();
        wait_done(2000, "r_done_seen");
        check_eq("r_hop_count", q_hop_idx.size(), 3);
        check_eq("r_last_idx", q_hop_idx[2], 2);
        check_eq("r_done_delay", q_done_cyc[0] - q_hop_cyc[2], 30);

        // start and stop together in IDLE
        clear_log();
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        tick(10);
        check_eq("ss_busy", busy, 0);
        check_eq("ss_no_req", q_pre_ints.size() + n_load, 0);

        check_eq("inv_both_high", v_both, 0);
        check_eq("inv_rise_busy", v_rise_busy, 0);
        check_eq("inv_data_stable", v_unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
